// File: rtl/stack_mem16_resp_if.sv
// Bus bundle for the dual-port stack memory: stack port, CPU port and fault record.
// The master modport belongs to the driving agent and the slave modport to the memory.
interface stack_mem16_resp_if;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  logic        clr_fault;
  logic        fault;
  logic [15:0] fault_addr;
  logic        fault_src;
  logic [7:0]  fault_cnt;

  modport master (
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output clr_fault,
    input  fault, fault_addr, fault_src, fault_cnt
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  clr_fault,
    output fault, fault_addr, fault_src, fault_cnt
  );
endinterface

// File: rtl/stack_mem16_resp.sv
// 16-bit word RAM shared by an always-ready stack port and a request/grant CPU port,
// with write-first reads, an address window check and a sticky fault record.
module stack_mem16_resp #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [15:0] BASE       = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  stack_mem16_resp_if.slave  bus
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = DEPTH_LOG2;
  localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = 8;

  logic [DW-1:0] ram [WORDS];

  logic [AW-1:0] stk_off;
  logic [AW-1:0] cpu_off;
  logic          stk_in;
  logic          cpu_in;
  logic [IW-1:0] stk_idx;
  logic [IW-1:0] cpu_idx;

  logic          cpu_gnt_c;
  logic          cpu_rd_go;
  logic          stk_wr;
  logic          cpu_wr;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] stk_rd_c;
  logic [DW-1:0] cpu_rd_c;

  logic          stk_fault;
  logic          cpu_fault;
  logic [1:0]    fault_inc;
  logic [CW:0]   cnt_sum;
  logic [CW-1:0] cnt_next;

  // Window decode: offset wraps mod 2**16, compared one bit wider so a full 64K window works
  assign stk_off = bus.mem_addr - BASE;
  assign cpu_off = bus.cpu_addr - BASE;
  assign stk_in  = ({1'b0, stk_off} < (AW+1)'(WORDS));
  assign cpu_in  = ({1'b0, cpu_off} < (AW+1)'(WORDS));
  assign stk_idx = stk_off[IW-1:0];
  assign cpu_idx = cpu_off[IW-1:0];

  // Only one RAM write per cycle, so a CPU write yields to a stack write
  assign cpu_gnt_c   = bus.cpu_req & (~bus.cpu_we | ~bus.mem_we);
  assign bus.cpu_gnt = cpu_gnt_c;
  assign cpu_rd_go   = cpu_gnt_c & ~bus.cpu_we;

  assign stk_wr  = bus.mem_we & stk_in;
  assign cpu_wr  = cpu_gnt_c & bus.cpu_we & cpu_in;
  assign wr_en   = stk_wr | cpu_wr;
  assign wr_idx  = stk_wr ? stk_idx : cpu_idx;
  assign wr_data = stk_wr ? bus.mem_wdata : bus.cpu_wdata;

  // Read muxes forward the same-cycle write so both ports see write-first data
  always_comb begin
    stk_rd_c = '0;
    cpu_rd_c = '0;
    if (stk_in) begin
      if (wr_en && (wr_idx == stk_idx)) stk_rd_c = wr_data;
      else                              stk_rd_c = ram[stk_idx];
    end
    if (cpu_in) begin
      if (wr_en && (wr_idx == cpu_idx)) cpu_rd_c = wr_data;
      else                              cpu_rd_c = ram[cpu_idx];
    end
  end

  // RAM array carries no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_rdata  <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
    end else begin
      bus.mem_rdata  <= stk_rd_c;
      bus.cpu_rvalid <= cpu_rd_go;
      if (cpu_rd_go) bus.cpu_rdata <= cpu_rd_c;
    end
  end

  // Stack-port reads outside the window are harmless; only writes and granted CPU accesses fault
  assign stk_fault = bus.mem_we & ~stk_in;
  assign cpu_fault = cpu_gnt_c & ~cpu_in;
  assign fault_inc = {1'b0, stk_fault} + {1'b0, cpu_fault};
  assign cnt_sum   = {1'b0, bus.fault_cnt} + {{(CW-1){1'b0}}, fault_inc};
  assign cnt_next  = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fault      <= 1'b0;
      bus.fault_addr <= '0;
      bus.fault_src  <= 1'b0;
      bus.fault_cnt  <= '0;
    end else if (bus.clr_fault) begin
      bus.fault      <= 1'b0;
      bus.fault_addr <= '0;
      bus.fault_src  <= 1'b0;
      bus.fault_cnt  <= '0;
    end else begin
      bus.fault_cnt <= cnt_next;
      if (!bus.fault && (stk_fault || cpu_fault)) begin
        bus.fault      <= 1'b1;
        bus.fault_addr <= stk_fault ? bus.mem_addr : bus.cpu_addr;
        bus.fault_src  <= ~stk_fault;
      end
    end
  end

endmodule

// File: tb/tb_stack_mem16_resp.sv
// Directed bench for stack_mem16_resp: stack/CPU access, arbitration, window faults,
// fault counter saturation, clear priority and asynchronous reset behaviour.
module tb_stack_mem16_resp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  stack_mem16_resp_if bus ();

  stack_mem16_resp #(.DEPTH_LOG2(8), .BASE(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_we    = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.clr_fault = 1'b0;
  endtask

  initial begin
    idle();
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 16'h0000;
    #1;
    // Reset values
    chk("rst_mem_rdata", bus.mem_rdata, 16'h0000);
    chk("rst_cpu_rvalid", 16'(bus.cpu_rvalid), 16'h0000);
    chk("rst_fault", 16'(bus.fault), 16'h0000);
    chk("rst_fault_cnt", 16'(bus.fault_cnt), 16'h0000);
    step(); step();
    rst = 1'b0;

    // Stack write then read back
    bus.mem_we = 1'b1; bus.mem_addr = 16'h000F; bus.mem_wdata = 16'hAAAA;
    step();
    bus.mem_we = 1'b0;
    step();
    chk("stk_read_0F", bus.mem_rdata, 16'hAAAA);

    // Write-first on the stack port
    bus.mem_we = 1'b1; bus.mem_addr = 16'h000E; bus.mem_wdata = 16'hBBBB;
    step();
    chk("stk_wfirst_0E", bus.mem_rdata, 16'hBBBB);
    bus.mem_addr = 16'h0000; bus.mem_wdata = 16'h5555;
    step();
    bus.mem_we = 1'b0;

    // CPU write blocked by a stack write, then granted
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0030; bus.mem_wdata = 16'h1111;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020; bus.cpu_wdata = 16'hC0DE;
    #1;
    chk("gnt_blocked", 16'(bus.cpu_gnt), 16'h0000);
    step();
    bus.mem_we = 1'b0;
    #1;
    chk("gnt_after_drop", 16'(bus.cpu_gnt), 16'h0001);
    step();
    bus.cpu_req = 1'b0;
    chk("wr_no_rvalid", 16'(bus.cpu_rvalid), 16'h0000);
    bus.mem_addr = 16'h0030;
    step();
    chk("stk_read_30", bus.mem_rdata, 16'h1111);

    // CPU read of the retried write, single rvalid pulse, then hold
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    #1;
    chk("gnt_read", 16'(bus.cpu_gnt), 16'h0001);
    step();
    bus.cpu_req = 1'b0;
    chk("rd20_rvalid", 16'(bus.cpu_rvalid), 16'h0001);
    chk("rd20_rdata", bus.cpu_rdata, 16'hC0DE);
    step();
    chk("rd20_rvalid_drop", 16'(bus.cpu_rvalid), 16'h0000);
    chk("rd20_rdata_hold", bus.cpu_rdata, 16'hC0DE);

    // Back-to-back CPU reads
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h000F;
    step();
    bus.cpu_addr = 16'h000E;
    chk("b2b_rvalid0", 16'(bus.cpu_rvalid), 16'h0001);
    chk("b2b_rdata0", bus.cpu_rdata, 16'hAAAA);
    step();
    bus.cpu_req = 1'b0;
    chk("b2b_rvalid1", 16'(bus.cpu_rvalid), 16'h0001);
    chk("b2b_rdata1", bus.cpu_rdata, 16'hBBBB);
    step();
    chk("b2b_rvalid_end", 16'(bus.cpu_rvalid), 16'h0000);

    // Out-of-window stack write faults and is discarded (index 0 must keep 5555)
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0100; bus.mem_wdata = 16'hDEAD;
    step();
    bus.mem_we = 1'b0;
    chk("f1_fault", 16'(bus.fault), 16'h0001);
    chk("f1_addr", bus.fault_addr, 16'h0100);
    chk("f1_src", 16'(bus.fault_src), 16'h0000);
    chk("f1_cnt", 16'(bus.fault_cnt), 16'h0001);
    chk("f1_oow_rdata", bus.mem_rdata, 16'h0000);
    bus.mem_addr = 16'h0000;
    step();
    chk("f1_ram_intact", bus.mem_rdata, 16'h5555);
    bus.mem_addr = 16'h0100;
    step();
    chk("oow_rd_zero", bus.mem_rdata, 16'h0000);
    chk("oow_rd_nofault", 16'(bus.fault_cnt), 16'h0001);

    // Out-of-window CPU read: rvalid with zero data, second fault keeps first address
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
    step();
    bus.cpu_req = 1'b0;
    chk("f2_rvalid", 16'(bus.cpu_rvalid), 16'h0001);
    chk("f2_rdata", bus.cpu_rdata, 16'h0000);
    chk("f2_cnt", 16'(bus.fault_cnt), 16'h0002);
    chk("f2_addr", bus.fault_addr, 16'h0100);

    // Clear
    bus.clr_fault = 1'b1;
    step();
    bus.clr_fault = 1'b0;
    chk("clr_fault", 16'(bus.fault), 16'h0000);
    chk("clr_addr", bus.fault_addr, 16'h0000);
    chk("clr_cnt", 16'(bus.fault_cnt), 16'h0000);

    // Both ports fault in one cycle: stack wins, count +2
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0300;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0400;
    step();
    idle();
    chk("dual_cnt", 16'(bus.fault_cnt), 16'h0002);
    chk("dual_addr", bus.fault_addr, 16'h0300);
    chk("dual_src", 16'(bus.fault_src), 16'h0000);

    // Clear wins over a same-cycle fault
    bus.clr_fault = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 16'h0300;
    step();
    idle();
    chk("clr_win_fault", 16'(bus.fault), 16'h0000);
    chk("clr_win_cnt", 16'(bus.fault_cnt), 16'h0000);

    // CPU-only first fault (write with stack idle)
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0500; bus.cpu_wdata = 16'h7777;
    step();
    idle();
    chk("cpu_f_src", 16'(bus.fault_src), 16'h0001);
    chk("cpu_f_addr", bus.fault_addr, 16'h0500);
    chk("cpu_f_cnt", 16'(bus.fault_cnt), 16'h0001);

    // Saturation
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0100;
    for (int i = 0; i < 300; i++) step();
    bus.mem_we = 1'b0;
    chk("sat_cnt", 16'(bus.fault_cnt), 16'h00FF);
    chk("sat_addr", bus.fault_addr, 16'h0500);

    // Data to survive reset
    bus.mem_we = 1'b1; bus.mem_addr = 16'h0042; bus.mem_wdata = 16'h4242;
    step();
    bus.mem_we = 1'b0;

    // Reset during a CPU read grant cycle
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0042;
    #1;
    chk("pre_rst_gnt", 16'(bus.cpu_gnt), 16'h0001);
    rst = 1'b1;
    #1;
    chk("rst_async_fault", 16'(bus.fault), 16'h0000);
    chk("rst_async_cnt", 16'(bus.fault_cnt), 16'h0000);
    chk("rst_async_mem", bus.mem_rdata, 16'h0000);
    chk("rst_async_cpu", bus.cpu_rdata, 16'h0000);
    step();
    chk("rst_no_rvalid", 16'(bus.cpu_rvalid), 16'h0000);
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_no_rvalid", 16'(bus.cpu_rvalid), 16'h0000);
    chk("post_rst_ram", bus.mem_rdata, 16'h4242);
    bus.cpu_req = 1'b1;
    step();
    bus.cpu_req = 1'b0;
    chk("post_rst_cpu_rd", bus.cpu_rdata, 16'h4242);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_mem16_resp.md
STACK_MEM16_RESP -- requirements
Module: stack_mem16_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, gives word count 2**DEPTH_LOG2 of internal RAM (16-bit words).
REQ-002 Parameter BASE, default 16'h0000, is the first word address of the RAM window.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 mem_we  in  1  stack-port write enable.
REQ-006 mem_addr  in  16  stack-port word address, sampled every cycle.
REQ-007 mem_wdata  in  16  stack-port write data.
REQ-008 mem_rdata  out  16  stack-port registered read data.
REQ-009 cpu_req  in  1  CPU-port access request, held until granted.
REQ-010 cpu_we  in  1  CPU-port write (1) / read (0), valid with cpu_req.
REQ-011 cpu_addr  in  16  CPU-port word address.
REQ-012 cpu_wdata  in  16  CPU-port write data.
REQ-013 cpu_gnt  out  1  combinational grant; access performed in this cycle.
REQ-014 cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
REQ-015 cpu_rdata  out  16  CPU-port registered read data.
REQ-016 clr_fault  in  1  synchronous clear of fault record.
REQ-017 fault  out  1  sticky out-of-window access flag.
REQ-018 fault_addr  out  16  address of first recorded fault.
REQ-019 fault_src  out  1  source of first fault: 0 stack port, 1 CPU port.
REQ-020 fault_cnt  out  8  count of faulting accesses, saturates at 8'hFF.

Function
REQ-021 Stack port SHALL be always ready: every cycle it performs a read of mem_addr, and a write when mem_we=1; no handshake.
REQ-022 mem_rdata SHALL present RAM[mem_addr] sampled at edge N on the output after edge N (1-cycle latency), updated every cycle.
REQ-023 Write-first: a read of an address written in the same cycle (by either port) SHALL return the newly written data.
REQ-024 Single write port: cpu_gnt SHALL be 0 when cpu_req=1, cpu_we=1 and mem_we=1; the CPU write is retried by holding cpu_req.
REQ-025 cpu_gnt SHALL be 1 whenever cpu_req=1 and the request is a read, or a write with mem_we=0.
REQ-026 Granted CPU write SHALL update RAM at the edge; no cpu_rvalid.
REQ-027 Granted CPU read SHALL assert cpu_rvalid for exactly the following cycle with cpu_rdata=RAM[cpu_addr]; back-to-back granted reads give back-to-back rvalid.
REQ-028 cpu_rdata SHALL hold its last value when cpu_rvalid=0.
REQ-029 In-window test: (addr - BASE) mod 2**16 < 2**DEPTH_LOG2; RAM index = low DEPTH_LOG2 bits of (addr - BASE).
REQ-030 Out-of-window stack write SHALL be discarded; out-of-window stack read SHALL yield mem_rdata=16'h0000.
REQ-031 Out-of-window granted CPU write discarded; read yields cpu_rdata=16'h0000 with cpu_rvalid still pulsed.
REQ-032 Faulting access = out-of-window stack write, or out-of-window granted CPU access; stack-port out-of-window reads alone SHALL NOT fault.
REQ-033 Each faulting access SHALL increment fault_cnt by 1 (by 2 if both ports fault in one cycle), saturating at 8'hFF.
REQ-034 On first fault while fault=0: fault<=1, fault_addr/fault_src capture it; stack port wins if both fault same cycle; later faults do not overwrite.
REQ-035 clr_fault=1 SHALL clear fault, fault_addr, fault_src, fault_cnt at the edge; clear wins over a same-cycle fault.

Reset
REQ-036 While rst=1: mem_rdata=0, cpu_rdata=0, cpu_rvalid=0, fault=0, fault_addr=0, fault_src=0, fault_cnt=0, immediately (asynchronous).
REQ-037 RAM contents SHALL NOT be reset; rst asserted mid-read SHALL suppress the pending cpu_rvalid.

Verification
REQ-038 Stack write 16'hAAAA @0x000F, then read 0x000F -> mem_rdata=16'hAAAA one cycle after the read address is sampled.
REQ-039 Same-cycle stack write 16'hBBBB and read @0x000E -> next-cycle mem_rdata=16'hBBBB (write-first).
REQ-040 CPU write request @0x0020 while mem_we=1 -> cpu_gnt=0; mem_we drops -> cpu_gnt=1, later CPU read returns the data with single rvalid pulse.
REQ-041 DEPTH_LOG2=8, BASE=0: stack write @0x0100 -> RAM unchanged, fault=1, fault_addr=16'h0100, fault_src=0, fault_cnt=1; further CPU fault @0x0200 -> cnt=2, addr unchanged.
REQ-042 Assert clr_fault -> all fault outputs 0 next cycle; 256 faults without clear -> fault_cnt stays 8'hFF.
REQ-043 Assert rst during CPU read grant cycle -> cpu_rvalid never pulses, all outputs 0; RAM data written before reset still readable after.
